// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the stream_mux_rr block.
package stream_mux_pkg;

  // Arbitration policy: round-robin over valid inputs, or external select.
  typedef enum logic {
    ARB_RR,
    ARB_SEL
  } arb_mode_e;

  // Index width for n channels. Never returns less than 1, so a port
  // carrying a channel index always has at least one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter. It searches the request vector starting
// at ptr and wraps from NUM_IN-1 to 0. The first requester found is granted.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = clog2_min1(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              gnt_vld,
  output logic [SEL_W-1:0]  gnt_idx
);

  // The loop scans offsets from the far end back toward ptr.
  // Because the last match wins, the requester nearest to ptr is granted.
  always_comb begin
    int             w_cand;
    logic [SEL_W-1:0] w_cand_idx;
    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    gnt_vld    = 1'b0;
    gnt_idx    = '0;
    w_cand     = 0;
    w_cand_idx = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      w_cand = int'(ptr) + k;
      if (w_cand >= NUM_IN) w_cand = w_cand - NUM_IN;
      w_cand_idx = SEL_W'(w_cand);
      if (req[w_cand_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = w_cand_idx;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// Registered N:1 stream multiplexer with a valid/ready handshake on every port.
// The grant comes from a round-robin arbiter or from the external sel input.
// One register stage sits on the output. out_src reports the producing channel.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int        NUM_IN   = 4,
  parameter  int        WIDTH    = 8,
  parameter  arb_mode_e ARB_MODE = ARB_RR,
  localparam int        SEL_W    = clog2_min1(NUM_IN)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [SEL_W-1:0]              sel,
  input  logic [NUM_IN-1:0][WIDTH-1:0]  in_data,
  input  logic [NUM_IN-1:0]             in_valid,
  output logic [NUM_IN-1:0]             in_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SEL_W-1:0]              out_src
);

  logic [SEL_W-1:0]  r_rr_ptr;
  logic [WIDTH-1:0]  r_out_data;
  logic              r_out_valid;
  logic [SEL_W-1:0]  r_out_src;

  logic              w_load_en;
  logic              w_arb_vld;
  logic [SEL_W-1:0]  w_arb_idx;
  logic              w_sel_vld;
  logic              w_grant_vld;
  logic [SEL_W-1:0]  w_grant_idx;
  logic [NUM_IN-1:0] w_in_ready;
  logic              w_xfer;
  logic [SEL_W-1:0]  w_next_ptr;

  rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
    .req     (in_valid),
    .ptr     (r_rr_ptr),
    .gnt_vld (w_arb_vld),
    .gnt_idx (w_arb_idx)
  );

  // The output register may reload when it is empty or is draining this cycle.
  // Because of this, a drain and an accept can happen in the same cycle.
  assign w_load_en = !r_out_valid || out_ready;

  // In select mode, a sel value outside the channel range means no grant.
  // The select grant does not depend on in_valid.
  assign w_sel_vld   = (int'(sel) < NUM_IN);
  assign w_grant_vld = (ARB_MODE == ARB_SEL) ? w_sel_vld : w_arb_vld;
  assign w_grant_idx = (ARB_MODE == ARB_SEL) ? sel       : w_arb_idx;

  // in_ready is one-hot on the granted channel, and only when the register can load.
  always_comb begin
    w_in_ready = '0;
    if (w_load_en && w_grant_vld) w_in_ready[w_grant_idx] = 1'b1;
  end

  assign w_xfer     = |(in_valid & w_in_ready);
  assign w_next_ptr = (w_grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : w_grant_idx + 1'b1;

  // Output stage: capture the granted beat on a transfer, or empty when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else if (w_load_en) begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= in_data[w_grant_idx];
        r_out_src   <= w_grant_idx;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Round-robin pointer: after a transfer it moves to one past the granted channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_xfer && (ARB_MODE == ARB_RR)) begin
      r_rr_ptr <= w_next_ptr;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed testbench for stream_mux_rr. It covers four configurations:
// 4-channel round-robin, 4-channel select, 3-channel select,
// and 5-channel 32-bit round-robin.
module tb_stream_mux_rr;
  import stream_mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // A: NUM_IN=4, WIDTH=8, round-robin
  logic [3:0][7:0] a_in_data;
  logic [3:0]      a_in_valid, a_in_ready;
  logic [7:0]      a_out_data;
  logic            a_out_valid, a_out_ready;
  logic [1:0]      a_out_src, a_sel;

  // B: NUM_IN=4, WIDTH=8, select
  logic [3:0][7:0] b_in_data;
  logic [3:0]      b_in_valid, b_in_ready;
  logic [7:0]      b_out_data;
  logic            b_out_valid, b_out_ready;
  logic [1:0]      b_out_src, b_sel;

  // C: NUM_IN=3, WIDTH=8, select
  logic [2:0][7:0] c_in_data;
  logic [2:0]      c_in_valid, c_in_ready;
  logic [7:0]      c_out_data;
  logic            c_out_valid, c_out_ready;
  logic [1:0]      c_out_src, c_sel;

  // D: NUM_IN=5, WIDTH=32, round-robin
  logic [4:0][31:0] d_in_data;
  logic [4:0]       d_in_valid, d_in_ready;
  logic [31:0]      d_out_data;
  logic             d_out_valid, d_out_ready;
  logic [2:0]       d_out_src, d_sel;

  stream_mux_rr #(.NUM_IN(4), .WIDTH(8), .ARB_MODE(ARB_RR)) u_rr (
    .clk(clk), .rst_n(rst_n), .sel(a_sel), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_src(a_out_src));

  stream_mux_rr #(.NUM_IN(4), .WIDTH(8), .ARB_MODE(ARB_SEL)) u_sel4 (
    .clk(clk), .rst_n(rst_n), .sel(b_sel), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_src(b_out_src));

  stream_mux_rr #(.NUM_IN(3), .WIDTH(8), .ARB_MODE(ARB_SEL)) u_sel3 (
    .clk(clk), .rst_n(rst_n), .sel(c_sel), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .out_data(c_out_data), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_src(c_out_src));

  stream_mux_rr #(.NUM_IN(5), .WIDTH(32), .ARB_MODE(ARB_RR)) u_wide (
    .clk(clk), .rst_n(rst_n), .sel(d_sel), .in_data(d_in_data), .in_valid(d_in_valid),
    .in_ready(d_in_ready), .out_data(d_out_data), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .out_src(d_out_src));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Absolute bound on run time.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a_in_data = '0; a_in_valid = '0; a_out_ready = 1'b0; a_sel = '0;
    b_in_data = '0; b_in_valid = '0; b_out_ready = 1'b0; b_sel = '0;
    c_in_data = '0; c_in_valid = '0; c_out_ready = 1'b0; c_sel = '0;
    d_in_data = '0; d_in_valid = '0; d_out_ready = 1'b0; d_sel = '0;
    tick();
    tick();

    // Reset state
    chk("rst_valid", a_out_valid, 0);
    chk("rst_data",  a_out_data,  0);
    chk("rst_src",   a_out_src,   0);
    chk("rst_ready", a_in_ready,  0);
    rst_n = 1'b1;

    // Test 1: all channels valid, then a mid-stream reset
    for (int i = 0; i < 4; i++) a_in_data[i] = 8'(8'h10 + i);
    a_in_valid  = 4'b1111;
    a_out_ready = 1'b1;
    #1;
    chk("t1_ready0", a_in_ready, 4'b0001);
    tick();
    chk("t1_valid0", a_out_valid, 1);
    chk("t1_src0",   a_out_src,   0);
    chk("t1_data0",  a_out_data,  8'h10);
    tick();
    chk("t1_src1",   a_out_src,   1);
    chk("t1_valid1", a_out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_valid", a_out_valid, 0);
    chk("t1_rst_data",  a_out_data,  0);
    chk("t1_rst_src",   a_out_src,   0);
    tick();
    rst_n = 1'b1;

    // Test 2: round-robin fairness, grants 0,1,2,3,0,1,2
    for (int k = 0; k < 7; k++) begin
      #1;
      chk($sformatf("t2_ready_%0d", k), a_in_ready, 1 << (k % 4));
      tick();
      chk($sformatf("t2_valid_%0d", k), a_out_valid, 1);
      chk($sformatf("t2_src_%0d", k),   a_out_src,   k % 4);
      chk($sformatf("t2_data_%0d", k),  a_out_data,  32'h10 + (k % 4));
    end

    // Test 3: sparse round-robin (rr_ptr is now 3); only ch0 and ch2 are valid
    a_in_valid = 4'b0101;
    a_in_data[0] = 8'h11;
    a_in_data[2] = 8'h22;
    #1;
    chk("t3_ready0", a_in_ready, 4'b0001);
    tick();
    chk("t3_data0", a_out_data, 8'h11);
    chk("t3_src0",  a_out_src,  0);
    tick();
    chk("t3_data1", a_out_data, 8'h22);
    chk("t3_src1",  a_out_src,  2);
    tick();
    chk("t3_data2", a_out_data, 8'h11);
    chk("t3_src2",  a_out_src,  0);

    // Test 4: backpressure (rr_ptr=1, so ch2 carries 0xA5)
    a_in_valid   = 4'b0100;
    a_in_data[2] = 8'hA5;
    tick();
    chk("t4_load_data", a_out_data, 8'hA5);
    chk("t4_load_src",  a_out_src,  2);
    a_out_ready = 1'b0;
    a_in_valid  = 4'b1111;
    for (int i = 0; i < 4; i++) a_in_data[i] = 8'(8'h10 + i);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("t4_stall_ready_%0d", k), a_in_ready, 4'b0000);
      tick();
      chk($sformatf("t4_stall_data_%0d", k),  a_out_data,  8'hA5);
      chk($sformatf("t4_stall_src_%0d", k),   a_out_src,   2);
      chk($sformatf("t4_stall_valid_%0d", k), a_out_valid, 1);
    end
    a_out_ready = 1'b1;
    #1;
    chk("t4_resume_ready", a_in_ready, 4'b1000);
    tick();
    chk("t4_next_data",  a_out_data,  8'h13);
    chk("t4_next_src",   a_out_src,   3);
    chk("t4_next_valid", a_out_valid, 1);
    a_in_valid = 4'b0000;
    tick();
    chk("t4_drain_valid", a_out_valid, 0);
    chk("t4_drain_data",  a_out_data,  8'h13);
    chk("t4_drain_src",   a_out_src,   3);

    // Test 5a: select mode with 4 channels
    b_out_ready  = 1'b1;
    b_in_data[1] = 8'h3C;
    b_in_data[2] = 8'h77;
    b_in_valid   = 4'b0010;
    b_sel        = 2'd2;
    #1;
    chk("t5_ready_novalid", b_in_ready, 4'b0100);
    tick();
    chk("t5_no_xfer_valid", b_out_valid, 0);
    b_sel = 2'd1;
    #1;
    chk("t5_ready_sel1", b_in_ready, 4'b0010);
    tick();
    chk("t5_data", b_out_data,  8'h3C);
    chk("t5_src",  b_out_src,   1);
    chk("t5_valid", b_out_valid, 1);
    b_out_ready  = 1'b0;
    b_sel        = 2'd3;
    b_in_data[1] = 8'h99;
    #1;
    chk("t5_stall_ready", b_in_ready, 4'b0000);
    tick();
    chk("t5_stall_data", b_out_data, 8'h3C);
    chk("t5_stall_src",  b_out_src,  1);

    // Test 5b: select mode with 3 channels; sel=3 is out of range
    c_out_ready = 1'b1;
    c_in_data[0] = 8'h0A;
    c_in_data[1] = 8'h0B;
    c_in_data[2] = 8'h0C;
    c_in_valid  = 3'b111;
    c_sel       = 2'd0;
    tick();
    chk("t5c_valid", c_out_valid, 1);
    chk("t5c_data",  c_out_data,  8'h0A);
    c_sel = 2'd3;
    #1;
    chk("t5c_ready_oob", c_in_ready, 3'b000);
    tick();
    chk("t5c_valid_fall", c_out_valid, 0);
    chk("t5c_data_hold",  c_out_data,  8'h0A);

    // Test 6: 5 channels at 32 bits; move rr_ptr to 4 first, then check the wrap
    d_out_ready  = 1'b1;
    d_in_valid   = 5'b01000;
    d_in_data[3] = 32'h33333333;
    tick();
    chk("t6_pre_src", d_out_src, 3);
    d_in_valid   = 5'b11111;
    d_in_data[0] = 32'h0BADF00D;
    d_in_data[1] = 32'h11111111;
    d_in_data[2] = 32'h22222222;
    d_in_data[4] = 32'hDEADBEEF;
    #1;
    chk("t6_ready4", d_in_ready, 5'b10000);
    tick();
    chk("t6_src4",  d_out_src,  4);
    chk("t6_data4", d_out_data, 32'hDEADBEEF);
    #1;
    chk("t6_ready0", d_in_ready, 5'b00001);
    tick();
    chk("t6_src0",  d_out_src,  0);
    chk("t6_data0", d_out_data, 32'h0BADF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
